uart_tx_queue: RTL

- Buffered transmit front end for the soft-core UART.
- Accepts bytes from the CPU-side write port into a synchronous FIFO.
- Issues them one at a time to the uart transmitter through its tx_start/tx_data/tx_busy handshake.
- Decouples software byte writes from the serial bit rate.

---
 rtl/uart_tx_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Buffered transmit front end: a byte FIFO filled from the CPU write port and
// drained one byte at a time into the UART through a start/busy handshake.
module uart_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TIMEOUT    = CW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] count_inc;
  logic          launch;
  logic          push;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign wr_ready  = (level != FULL_LEVEL);
  assign empty     = (level == '0);
  assign push      = wr_en && wr_ready && !flush;
  assign count_inc = count + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // A launch is held off during flush so the popped byte can never be one
  // that the same edge is discarding.
  always_comb begin
    state_next = state;
    count_next = count;
    launch     = 1'b0;
    tx_start   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          launch     = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start   = 1'b1;
        count_next = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else begin
          count_next = count_inc;
          if (count_inc == TIMEOUT) begin
            state_next = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (launch) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, launch})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // tx_data only moves on a launch, so it stays put for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data <= 8'h00;
    end else if (launch) begin
      tx_data <= mem[rd_ptr];
    end
  end

  // A fresh overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (wr_en && !wr_ready && !flush) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
